hub75_rx: RTL and testbench

HUB75_RX -- requirements
Module: hub75_rx

---
 rtl/hub75_pkg.sv | 29 ++
 rtl/hub75_rx_sync.sv | 62 ++++++
 rtl/hub75_rx.sv | 188 ++++++++++++++++++
 tb/tb_hub75_rx.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 line receiver: pixel payload, row address, read FSM states.
package hub75_pkg;

   localparam int unsigned HUB75_ROW_W = 5;
   localparam int unsigned HUB75_PIX_W = 6;

   // One shifted pixel: upper half (r0,g0,b0) and lower half (r1,g1,b1)
   typedef struct packed {
      logic r0;
      logic g0;
      logic b0;
      logic r1;
      logic g1;
      logic b1;
   } pixel_t;

   typedef logic [HUB75_ROW_W-1:0] row_addr_t;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_e;

   // Stream byte layout: {2'b00, b1, g1, r1, b0, g0, r0}
   function automatic logic [7:0] pixel_to_tdata(input pixel_t p);
      return {2'b00, p.b1, p.g1, p.r1, p.b0, p.g0, p.r0};
   endfunction

endpackage

// File: rtl/hub75_rx_sync.sv
// Synchronizes every HUB75 pin into the system clock domain and emits
// registered shift-clock / latch rising-edge pulses aligned with the data.
module hub75_rx_sync
   import hub75_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      hub_clk_i,
   input  logic      hub_lat_i,
   input  logic      hub_oe_i,
   input  row_addr_t row_i,
   input  pixel_t    rgb_i,
   output logic      clk_rise_o,
   output logic      lat_rise_o,
   output logic      oe_o,
   output row_addr_t row_o,
   output pixel_t    rgb_o
);

   localparam int unsigned VEC_W   = 3 + HUB75_ROW_W + HUB75_PIX_W;
   localparam int unsigned CLK_BIT = VEC_W - 1;
   localparam int unsigned LAT_BIT = VEC_W - 2;
   localparam int unsigned OE_BIT  = VEC_W - 3;

   typedef logic [VEC_W-1:0] vec_t;

   vec_t pin_vec;
   vec_t stage_q [SYNC_STAGES];
   vec_t last_s;
   logic clk_prev_q;
   logic lat_prev_q;

   assign pin_vec = {hub_clk_i, hub_lat_i, hub_oe_i, row_i, rgb_i};
   assign last_s  = stage_q[SYNC_STAGES-1];

   // Synchronizer chain, edge detect on the last two samples, aligned data outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
         clk_prev_q <= 1'b0;
         lat_prev_q <= 1'b0;
         clk_rise_o <= 1'b0;
         lat_rise_o <= 1'b0;
         oe_o       <= 1'b0;
         row_o      <= '0;
         rgb_o      <= '0;
      end else begin
         stage_q[0] <= pin_vec;
         for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
         clk_prev_q <= last_s[CLK_BIT];
         lat_prev_q <= last_s[LAT_BIT];
         clk_rise_o <= last_s[CLK_BIT] & ~clk_prev_q;
         lat_rise_o <= last_s[LAT_BIT] & ~lat_prev_q;
         oe_o       <= last_s[OE_BIT];
         row_o      <= row_addr_t'(last_s[HUB75_PIX_W +: HUB75_ROW_W]);
         rgb_o      <= pixel_t'(last_s[HUB75_PIX_W-1:0]);
      end
   end

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-bus receiver: captures shifted lines into a double-buffered
// line memory and replays each complete line as an AXI-Stream packet.
// Optional statistics counters are built when HUB75_RX_STATS_EN is defined.
module hub75_rx
   import hub75_pkg::*;
#(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       hub75io_clk,
   input  logic       hub75io_lat,
   input  logic       hub75io_oe,
   input  logic [1:0] hub75io_r,
   input  logic [1:0] hub75io_g,
   input  logic [1:0] hub75io_b,
   input  logic       hub75io_row_a,
   input  logic       hub75io_row_b,
   input  logic       hub75io_row_c,
   input  logic       hub75io_row_d,
   input  logic       hub75io_row_e,
   output logic [7:0] maxis_tdata,
   output logic       maxis_tvalid,
   input  logic       maxis_tready,
   output logic       maxis_tlast,
   output logic       maxis_tuser,
   output logic [4:0] row_addr,
   output logic [15:0] drop_count,
   output logic [15:0] len_err_count
);

   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
   localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(WIDTH - 2);

   row_addr_t pin_row;
   pixel_t    pin_pix;
   logic      clk_rise;
   logic      lat_rise;
   logic      oe_unused;
   row_addr_t sync_row;
   pixel_t    sync_pix;

   pixel_t     bank_q [2][WIDTH];
   logic       bank_sel_q;
   logic [CNT_W-1:0] pix_cnt_q;
   logic [CNT_W-1:0] pix_cnt_d;
   logic [CNT_W-1:0] line_len;
   logic       line_full;
   logic       swap;

   rd_state_e  state_q;
   logic [IDX_W-1:0] rd_idx_q;
   logic [IDX_W-1:0] rd_idx_d;
   logic       tvalid_q;
   logic       tlast_q;
   logic       tuser_q;
   logic [7:0] tdata_q;
   row_addr_t  row_q;

   assign pin_row = {hub75io_row_e, hub75io_row_d, hub75io_row_c, hub75io_row_b, hub75io_row_a};
   assign pin_pix = {hub75io_r[0], hub75io_g[0], hub75io_b[0],
                     hub75io_r[1], hub75io_g[1], hub75io_b[1]};

   hub75_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i      (clock),
      .rst_i      (reset),
      .hub_clk_i  (hub75io_clk),
      .hub_lat_i  (hub75io_lat),
      .hub_oe_i   (hub75io_oe),
      .row_i      (pin_row),
      .rgb_i      (pin_pix),
      .clk_rise_o (clk_rise),
      .lat_rise_o (lat_rise),
      .oe_o       (oe_unused),
      .row_o      (sync_row),
      .rgb_o      (sync_pix)
   );

   // Saturating pixel count; a clk rise coincident with the latch counts toward the line
   assign pix_cnt_d = (pix_cnt_q == CNT_SAT) ? CNT_SAT : pix_cnt_q + CNT_W'(1);
   assign line_len  = clk_rise ? pix_cnt_d : pix_cnt_q;
   assign line_full = lat_rise && (line_len == CNT_FULL);
   assign swap      = line_full && (state_q == IDLE);
   assign rd_idx_d  = rd_idx_q + IDX_W'(1);

   // Line capture into the write bank; writes beyond the line width are discarded
   always_ff @(posedge clock) begin
      if (clk_rise && !pix_cnt_q[IDX_W]) begin
         bank_q[bank_sel_q][pix_cnt_q[IDX_W-1:0]] <= sync_pix;
      end
   end

   // Pixel counter: advances per shifted pixel, cleared by every latch
   always_ff @(posedge clock) begin
      if (reset) begin
         pix_cnt_q <= '0;
      end else if (lat_rise) begin
         pix_cnt_q <= '0;
      end else if (clk_rise) begin
         pix_cnt_q <= pix_cnt_d;
      end
   end

   // Read FSM: bank swap on an accepted line, then one beat per handshake
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         bank_sel_q <= 1'b0;
         rd_idx_q   <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tuser_q    <= 1'b0;
         tdata_q    <= '0;
         row_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (swap) begin
                  state_q    <= STREAM;
                  bank_sel_q <= ~bank_sel_q;
                  row_q      <= sync_row;
                  rd_idx_q   <= '0;
                  tvalid_q   <= 1'b1;
                  tuser_q    <= 1'b1;
                  tlast_q    <= 1'b0;
                  tdata_q    <= pixel_to_tdata(bank_q[bank_sel_q][0]);
               end
            end
            STREAM: begin
               if (tvalid_q && maxis_tready) begin
                  if (tlast_q) begin
                     state_q  <= IDLE;
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     tuser_q  <= 1'b0;
                  end else begin
                     rd_idx_q <= rd_idx_d;
                     tuser_q  <= 1'b0;
                     tlast_q  <= (rd_idx_q == IDX_PENULT);
                     tdata_q  <= pixel_to_tdata(bank_q[~bank_sel_q][rd_idx_d]);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign maxis_tdata  = tdata_q;
   assign maxis_tvalid = tvalid_q;
   assign maxis_tlast  = tlast_q;
   assign maxis_tuser  = tuser_q;
   assign row_addr     = row_q;

`ifdef HUB75_RX_STATS_EN
   logic        drop_evt;
   logic        len_err_evt;
   logic [15:0] drop_cnt_q;
   logic [15:0] len_err_cnt_q;

   assign drop_evt    = line_full && (state_q == STREAM);
   assign len_err_evt = lat_rise && (line_len != CNT_FULL);

   // Saturating statistics for dropped and wrong-length lines
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_cnt_q    <= '0;
         len_err_cnt_q <= '0;
      end else begin
         if (drop_evt && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
         if (len_err_evt && (len_err_cnt_q != 16'hFFFF)) len_err_cnt_q <= len_err_cnt_q + 16'd1;
      end
   end

   assign drop_count    = drop_cnt_q;
   assign len_err_count = len_err_cnt_q;
`else
   assign drop_count    = 16'h0000;
   assign len_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Directed testbench for hub75_rx (WIDTH=64, SYNC_STAGES=2).
module tb_hub75_rx;

   localparam int unsigned WIDTH       = 64;
   localparam int unsigned SYNC_STAGES = 2;
`ifdef HUB75_RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clock;
   logic       reset;
   logic       hub75io_clk, hub75io_lat, hub75io_oe;
   logic [1:0] hub75io_r, hub75io_g, hub75io_b;
   logic       hub75io_row_a, hub75io_row_b, hub75io_row_c, hub75io_row_d, hub75io_row_e;
   logic [7:0] maxis_tdata;
   logic       maxis_tvalid, maxis_tready, maxis_tlast, maxis_tuser;
   logic [4:0] row_addr;
   logic [15:0] drop_count, len_err_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] cap_data [128];
   logic       cap_user [128];
   logic       cap_last [128];
   logic [4:0] cap_row  [128];

   hub75_rx #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .hub75io_clk   (hub75io_clk),
      .hub75io_lat   (hub75io_lat),
      .hub75io_oe    (hub75io_oe),
      .hub75io_r     (hub75io_r),
      .hub75io_g     (hub75io_g),
      .hub75io_b     (hub75io_b),
      .hub75io_row_a (hub75io_row_a),
      .hub75io_row_b (hub75io_row_b),
      .hub75io_row_c (hub75io_row_c),
      .hub75io_row_d (hub75io_row_d),
      .hub75io_row_e (hub75io_row_e),
      .maxis_tdata   (maxis_tdata),
      .maxis_tvalid  (maxis_tvalid),
      .maxis_tready  (maxis_tready),
      .maxis_tlast   (maxis_tlast),
      .maxis_tuser   (maxis_tuser),
      .row_addr      (row_addr),
      .drop_count    (drop_count),
      .len_err_count (len_err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // Pixel value v maps to tdata[5:0] == v
   task automatic drive_pixel(input logic [5:0] v);
      hub75io_r = {v[3], v[0]};
      hub75io_g = {v[4], v[1]};
      hub75io_b = {v[5], v[2]};
   endtask

   task automatic set_row(input logic [4:0] row);
      {hub75io_row_e, hub75io_row_d, hub75io_row_c, hub75io_row_b, hub75io_row_a} = row;
   endtask

   // Shift n pixels (value = index ^ mask) at a quarter of the system clock
   task automatic shift_line(input int n, input logic [5:0] mask);
      for (int i = 0; i < n; i++) begin
         drive_pixel(6'(i) ^ mask);
         hub75io_clk = 1'b0;
         repeat (2) @(negedge clock);
         hub75io_clk = 1'b1;
         repeat (2) @(negedge clock);
      end
      hub75io_clk = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic latch_line(input logic [4:0] row);
      set_row(row);
      hub75io_lat = 1'b1;
      repeat (2) @(negedge clock);
      hub75io_lat = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   // Receive one packet into cap_*; toggle selects a 1-0-1 tready pattern
   task automatic capture_line(input bit toggle, input int budget, output int nbeats,
                               output int ncyc, output bit stable_ok, output bit timed_out);
      logic [7:0] p_data;
      logic       p_user, p_last;
      logic [4:0] p_row;
      bit         stalled, last_accept;
      nbeats = 0; ncyc = 0; stable_ok = 1'b1; timed_out = 1'b1; stalled = 1'b0;
      p_data = '0; p_user = 1'b0; p_last = 1'b0; p_row = '0;
      for (int i = 0; i < 128; i++) begin
         cap_data[i] = 8'hFF; cap_user[i] = 1'b0; cap_last[i] = 1'b0; cap_row[i] = 5'h1F;
      end
      for (int c = 0; c < budget; c++) begin
         if (stalled && (!maxis_tvalid ||
             {maxis_tdata, maxis_tuser, maxis_tlast, row_addr} !== {p_data, p_user, p_last, p_row}))
            stable_ok = 1'b0;
         maxis_tready = toggle ? (c % 2 == 0) : 1'b1;
         if (maxis_tvalid && maxis_tready && nbeats < 128) begin
            cap_data[nbeats] = maxis_tdata;
            cap_user[nbeats] = maxis_tuser;
            cap_last[nbeats] = maxis_tlast;
            cap_row[nbeats]  = row_addr;
            nbeats++;
         end
         stalled     = maxis_tvalid && !maxis_tready;
         last_accept = maxis_tvalid && maxis_tready && maxis_tlast;
         p_data = maxis_tdata; p_user = maxis_tuser; p_last = maxis_tlast; p_row = row_addr;
         @(negedge clock);
         ncyc = c + 1;
         if (last_accept) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({maxis_tvalid, maxis_tlast, maxis_tuser} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got valid/last/user=%b, want 000", {maxis_tvalid, maxis_tlast, maxis_tuser});
      end
      n_checks++;
      if ({maxis_tdata, row_addr, drop_count, len_err_count} !== 45'd0) begin
         n_fail++;
         $display("FAIL reset_values: got tdata=%h row=%0d drop=%0d lenerr=%0d, want all 0",
                  maxis_tdata, row_addr, drop_count, len_err_count);
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_basic();
      int first, nb, nc;
      bit st, to;
      maxis_tready = 1'b0;
      shift_line(64, 6'h00);
      set_row(5'd7);
      hub75io_lat = 1'b1;
      first = -1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (k == 2) hub75io_lat = 1'b0;
         if (maxis_tvalid && first < 0) first = k;
      end
      n_checks++;
      if (first != SYNC_STAGES + 2) begin
         n_fail++;
         $display("FAIL basic_latency: tvalid after %0d clocks, want %0d", first, SYNC_STAGES + 2);
      end
      n_checks++;
      if ({maxis_tdata, maxis_tuser, maxis_tlast, row_addr} !== {8'd0, 1'b1, 1'b0, 5'd7}) begin
         n_fail++;
         $display("FAIL basic_first_beat: got data=%h user=%b last=%b row=%0d, want 00 1 0 7",
                  maxis_tdata, maxis_tuser, maxis_tlast, row_addr);
      end
      capture_line(1'b0, 400, nb, nc, st, to);
      n_checks++;
      if (to || nb != 64 || nc != 64) begin
         n_fail++;
         $display("FAIL basic_count: got beats=%0d cycles=%0d timeout=%b, want 64 64 0", nb, nc, to);
      end
      for (int i = 0; i < 64; i++) begin
         n_checks++;
         if ({cap_data[i], cap_user[i], cap_last[i], cap_row[i]} !== {8'(i), i == 0, i == 63, 5'd7}) begin
            n_fail++;
            $display("FAIL basic_beat[%0d]: got data=%h user=%b last=%b row=%0d, want data=%h user=%b last=%b row=7",
                     i, cap_data[i], cap_user[i], cap_last[i], cap_row[i], 8'(i), i == 0, i == 63);
         end
      end
      n_checks++;
      if (maxis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_idle_after: got tvalid=%b, want 0", maxis_tvalid);
      end
   endtask

   task automatic test_stall();
      int nb, nc;
      bit st, to;
      maxis_tready = 1'b0;
      shift_line(64, 6'h00);
      latch_line(5'd7);
      capture_line(1'b1, 400, nb, nc, st, to);
      n_checks++;
      if (to || nb != 64) begin
         n_fail++;
         $display("FAIL stall_count: got beats=%0d timeout=%b, want 64 0", nb, to);
      end
      n_checks++;
      if (st !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_stable: outputs changed during stall (flag=%b), want 1", st);
      end
      for (int i = 0; i < 64; i++) begin
         n_checks++;
         if ({cap_data[i], cap_user[i], cap_last[i], cap_row[i]} !== {8'(i), i == 0, i == 63, 5'd7}) begin
            n_fail++;
            $display("FAIL stall_beat[%0d]: got data=%h user=%b last=%b row=%0d, want data=%h user=%b last=%b row=7",
                     i, cap_data[i], cap_user[i], cap_last[i], cap_row[i], 8'(i), i == 0, i == 63);
         end
      end
   endtask

   task automatic test_drop();
      int nb, nc;
      bit st, to, seen;
      maxis_tready = 1'b0;
      shift_line(64, 6'h00);
      latch_line(5'd7);
      shift_line(64, 6'h15);
      latch_line(5'd9);
      repeat (10) @(negedge clock);
      n_checks++;
      if ({maxis_tvalid, maxis_tdata, maxis_tuser, row_addr} !== {1'b1, 8'd0, 1'b1, 5'd7}) begin
         n_fail++;
         $display("FAIL drop_hold: got valid=%b data=%h user=%b row=%0d, want 1 00 1 7",
                  maxis_tvalid, maxis_tdata, maxis_tuser, row_addr);
      end
      n_checks++;
      if (drop_count !== (STATS ? 16'd1 : 16'd0)) begin
         n_fail++;
         $display("FAIL drop_count: got %0d, want %0d", drop_count, STATS ? 1 : 0);
      end
      capture_line(1'b0, 400, nb, nc, st, to);
      n_checks++;
      if (to || nb != 64) begin
         n_fail++;
         $display("FAIL drop_count_beats: got beats=%0d timeout=%b, want 64 0", nb, to);
      end
      for (int i = 0; i < 64; i++) begin
         n_checks++;
         if ({cap_data[i], cap_user[i], cap_last[i], cap_row[i]} !== {8'(i), i == 0, i == 63, 5'd7}) begin
            n_fail++;
            $display("FAIL drop_beat[%0d]: got data=%h user=%b last=%b row=%0d, want data=%h user=%b last=%b row=7",
                     i, cap_data[i], cap_user[i], cap_last[i], cap_row[i], 8'(i), i == 0, i == 63);
         end
      end
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (maxis_tvalid) seen = 1'b1;
         @(negedge clock);
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_second_line: dropped line was streamed (tvalid seen=%b), want 0", seen);
      end
   endtask

   task automatic test_len_err();
      int nb, nc;
      bit st, to, seen;
      maxis_tready = 1'b1;
      seen = 1'b0;
      shift_line(63, 6'h00);
      latch_line(5'd3);
      for (int k = 0; k < 10; k++) begin
         if (maxis_tvalid) seen = 1'b1;
         @(negedge clock);
      end
      shift_line(70, 6'h00);
      latch_line(5'd4);
      for (int k = 0; k < 10; k++) begin
         if (maxis_tvalid) seen = 1'b1;
         @(negedge clock);
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL len_err_stream: short/long line was streamed (tvalid seen=%b), want 0", seen);
      end
      n_checks++;
      if ({len_err_count, drop_count} !== (STATS ? {16'd2, 16'd1} : 32'd0)) begin
         n_fail++;
         $display("FAIL len_err_count: got lenerr=%0d drop=%0d, want lenerr=%0d drop=%0d",
                  len_err_count, drop_count, STATS ? 2 : 0, STATS ? 1 : 0);
      end
      maxis_tready = 1'b0;
      shift_line(64, 6'h3F);
      latch_line(5'd12);
      capture_line(1'b0, 400, nb, nc, st, to);
      n_checks++;
      if (to || nb != 64) begin
         n_fail++;
         $display("FAIL len_err_recover_count: got beats=%0d timeout=%b, want 64 0", nb, to);
      end
      for (int i = 0; i < 64; i++) begin
         n_checks++;
         if ({cap_data[i], cap_user[i], cap_last[i], cap_row[i]} !== {8'(6'(i) ^ 6'h3F), i == 0, i == 63, 5'd12}) begin
            n_fail++;
            $display("FAIL len_err_beat[%0d]: got data=%h user=%b last=%b row=%0d, want data=%h user=%b last=%b row=12",
                     i, cap_data[i], cap_user[i], cap_last[i], cap_row[i], 8'(6'(i) ^ 6'h3F), i == 0, i == 63);
         end
      end
   endtask

   task automatic test_same_cycle();
      int nb, nc;
      bit st, to;
      maxis_tready = 1'b0;
      shift_line(63, 6'h2A);
      drive_pixel(6'd63 ^ 6'h2A);
      set_row(5'd21);
      repeat (2) @(negedge clock);
      hub75io_clk = 1'b1;
      hub75io_lat = 1'b1;
      repeat (2) @(negedge clock);
      hub75io_clk = 1'b0;
      hub75io_lat = 1'b0;
      repeat (2) @(negedge clock);
      capture_line(1'b0, 400, nb, nc, st, to);
      n_checks++;
      if (to || nb != 64) begin
         n_fail++;
         $display("FAIL same_cycle_count: got beats=%0d timeout=%b, want 64 0", nb, to);
      end
      for (int i = 0; i < 64; i++) begin
         n_checks++;
         if ({cap_data[i], cap_user[i], cap_last[i], cap_row[i]} !== {8'(6'(i) ^ 6'h2A), i == 0, i == 63, 5'd21}) begin
            n_fail++;
            $display("FAIL same_cycle_beat[%0d]: got data=%h user=%b last=%b row=%0d, want data=%h user=%b last=%b row=21",
                     i, cap_data[i], cap_user[i], cap_last[i], cap_row[i], 8'(6'(i) ^ 6'h2A), i == 0, i == 63);
         end
      end
   endtask

   task automatic test_reset_mid();
      int got, nb, nc;
      bit st, to, hit;
      maxis_tready = 1'b0;
      shift_line(64, 6'h0A);
      latch_line(5'd5);
      got = 0;
      hit = 1'b0;
      maxis_tready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (maxis_tvalid) begin
            if (got == 20) begin
               hit = 1'b1;
               reset = 1'b1;
               break;
            end
            got++;
         end
         @(negedge clock);
      end
      @(negedge clock);
      reset = 1'b0;
      n_checks++;
      if (hit !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_reach: beat 20 reached=%b after %0d beats, want 1", hit, got);
      end
      n_checks++;
      if ({maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tdata, row_addr} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got valid=%b last=%b user=%b data=%h row=%0d, want all 0",
                  maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tdata, row_addr);
      end
      n_checks++;
      if ({drop_count, len_err_count} !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_counters: got drop=%0d lenerr=%0d, want 0 0", drop_count, len_err_count);
      end
      maxis_tready = 1'b0;
      repeat (2) @(negedge clock);
      shift_line(64, 6'h11);
      latch_line(5'd30);
      capture_line(1'b0, 400, nb, nc, st, to);
      n_checks++;
      if (to || nb != 64) begin
         n_fail++;
         $display("FAIL reset_mid_next_count: got beats=%0d timeout=%b, want 64 0", nb, to);
      end
      for (int i = 0; i < 64; i++) begin
         n_checks++;
         if ({cap_data[i], cap_user[i], cap_last[i], cap_row[i]} !== {8'(6'(i) ^ 6'h11), i == 0, i == 63, 5'd30}) begin
            n_fail++;
            $display("FAIL reset_mid_beat[%0d]: got data=%h user=%b last=%b row=%0d, want data=%h user=%b last=%b row=30",
                     i, cap_data[i], cap_user[i], cap_last[i], cap_row[i], 8'(6'(i) ^ 6'h11), i == 0, i == 63);
         end
      end
      n_checks++;
      if ({drop_count, len_err_count} !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_first_line: got drop=%0d lenerr=%0d, want 0 0", drop_count, len_err_count);
      end
   endtask

   initial begin
      reset        = 1'b1;
      hub75io_clk  = 1'b0;
      hub75io_lat  = 1'b0;
      hub75io_oe   = 1'b0;
      hub75io_r    = '0;
      hub75io_g    = '0;
      hub75io_b    = '0;
      maxis_tready = 1'b0;
      set_row(5'd0);
      @(negedge clock);
      test_reset();
      test_basic();
      test_stall();
      test_drop();
      test_len_err();
      test_same_cycle();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
